// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: base opcodes, fetch FSM states and the
// default boot address.
package riscv_pkg;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] JAL    = 7'h6F;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] BRANCH = 7'h63;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_REQ     = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry fetch buffer holding {pc, instr}; flush empties it in one cycle and
// push/pop may coincide.
module fetch_fifo #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [0:1];
    logic             rd_ptr;
    logic             wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory request FSM feeding a
// two-entry buffer toward decode, with redirect flush and discard of stale data.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [2:0]  id_funct3,
    output logic [6:0]  id_funct7,
    output logic [31:0] instr_count
);

    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  fetch_pc;
    logic [31:0]  discard_pc;
    logic [1:0]   fifo_count;
    logic [63:0]  fifo_dout;
    logic         push;
    logic         pop;
    logic [1:0]   occ_after_pop;
    logic [1:0]   occ_after_push;

    assign imem_req  = (state != FETCH_IDLE);
    // While discarding, the abandoned address stays on the bus until its ack.
    assign imem_addr = (state == FETCH_DISCARD) ? discard_pc : fetch_pc;

    assign id_valid  = (fifo_count != 2'd0);
    assign pop       = id_valid & id_ready;
    assign push      = (state == FETCH_REQ) && imem_ack && !redirect_valid;

    assign occ_after_pop  = fifo_count - {1'b0, pop};
    assign occ_after_push = occ_after_pop + {1'b0, push};

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE: begin
                if (redirect_valid || (occ_after_pop < DEPTH)) state_nxt = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (redirect_valid)
                    state_nxt = imem_ack ? FETCH_IDLE : FETCH_DISCARD;
                else if (imem_ack)
                    state_nxt = (occ_after_push < DEPTH) ? FETCH_REQ : FETCH_IDLE;
            end
            FETCH_DISCARD: begin
                if (imem_ack) state_nxt = FETCH_IDLE;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_IDLE;
            fetch_pc    <= RESET_PC;
            instr_count <= 32'd0;
        end else begin
            state <= state_nxt;
            if (redirect_valid)
                fetch_pc <= align_pc(redirect_pc);
            else if (push)
                fetch_pc <= fetch_pc + 32'd4;
            if (pop)
                instr_count <= instr_count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == FETCH_REQ && redirect_valid && !imem_ack)
            discard_pc <= fetch_pc;
    end

    fetch_fifo #(
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({fetch_pc, imem_rdata}),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign id_pc     = fifo_dout[63:32];
    assign id_instr  = fifo_dout[31:0];
    assign id_opcode = id_instr[6:0];
    assign id_funct3 = id_instr[14:12];
    assign id_funct7 = id_instr[31:25];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, back-pressure, redirects, PC wrap and
// reset behaviour against a latency-programmable instruction memory.
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RP = 32'h0000_0200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic [31:0] instr_count;

    int checks   = 0;
    int failures = 0;
    int mem_lat  = 0;
    int wcnt     = 0;

    if_stage #(.RESET_PC(RP), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc),
        .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] op;
        case (a[4:2])
            3'd0: op = OP_IMM;
            3'd1: op = LOAD;
            3'd2: op = OP;
            3'd3: op = JAL;
            3'd4: op = STORE;
            3'd5: op = LUI;
            3'd6: op = BRANCH;
            default: op = OP_IMM;
        endcase
        return {a[31:7] ^ 25'h0AB_CDEF, op};
    endfunction

    // Memory acks after mem_lat wait cycles; it shares rst with the DUT.
    assign imem_ack   = imem_req && !rst && (wcnt == mem_lat);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wcnt <= 0;
        else                              wcnt <= wcnt + 1;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        mem_lat = 0;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        id_ready = 1'b1;
        mem_lat = 0;
        step;
        step;
        checks++;
        if ({imem_req, id_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_outputs actual req/valid=%b required=00", {imem_req, id_valid});
        end
        checks++;
        if (instr_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_count actual=%0d required=0", instr_count);
        end
        rst = 1'b0;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_req actual=%b required=0", imem_req);
        end
        step;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RP}) begin
            failures++;
            $display("FAIL first_req actual req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RP);
        end
    endtask

    task automatic test_stream;
        logic [31:0] epc;
        logic [31:0] e;
        do_reset;
        id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step;
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, RP + 32'(4 * k)}) begin
                failures++;
                $display("FAIL stream_addr k=%0d actual req=%b addr=%h required addr=%h", k, imem_req, imem_addr, RP + 32'(4 * k));
            end
            if (k >= 1) begin
                epc = RP + 32'(4 * (k - 1));
                e = mem_word(epc);
                checks++;
                if ({id_valid, id_pc, id_instr} !== {1'b1, epc, e}) begin
                    failures++;
                    $display("FAIL stream_id k=%0d actual valid=%b pc=%h instr=%h required pc=%h instr=%h", k, id_valid, id_pc, id_instr, epc, e);
                end
                checks++;
                if ({id_funct7, id_funct3, id_opcode} !== {e[31:25], e[14:12], e[6:0]}) begin
                    failures++;
                    $display("FAIL stream_fields k=%0d actual f7=%h f3=%h op=%h required f7=%h f3=%h op=%h", k, id_funct7, id_funct3, id_opcode, e[31:25], e[14:12], e[6:0]);
                end
                checks++;
                if (instr_count !== 32'(k - 1)) begin
                    failures++;
                    $display("FAIL stream_count k=%0d actual=%0d required=%0d", k, instr_count, k - 1);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        do_reset;
        step;
        step;
        step;
        held = mem_word(RP);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({imem_req, id_valid, id_pc, id_instr} !== {1'b0, 1'b1, RP, held}) begin
                failures++;
                $display("FAIL bp_hold k=%0d actual req=%b valid=%b pc=%h instr=%h required req=0 valid=1 pc=%h instr=%h", k, imem_req, id_valid, id_pc, id_instr, RP, held);
            end
            if (k < 2) step;
        end
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step;
            checks++;
            if ({id_valid, id_pc} !== {1'b1, RP + 32'(4 * i)}) begin
                failures++;
                $display("FAIL bp_drain i=%0d actual valid=%b pc=%h required pc=%h", i, id_valid, id_pc, RP + 32'(4 * i));
            end
        end
        step;
        checks++;
        if ({instr_count, id_pc} !== {32'd6, RP + 32'd24}) begin
            failures++;
            $display("FAIL bp_count actual count=%0d pc=%h required count=6 pc=%h", instr_count, id_pc, RP + 32'd24);
        end
    endtask

    task automatic test_redirect_latency;
        bit found;
        do_reset;
        id_ready = 1'b1;
        mem_lat = 3;
        step;
        step;
        checks++;
        if ({imem_req, imem_ack, imem_addr} !== {1'b1, 1'b0, RP}) begin
            failures++;
            $display("FAIL rl_pending actual req=%b ack=%b addr=%h required req=1 ack=0 addr=%h", imem_req, imem_ack, imem_addr, RP);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step;
        redirect_valid = 1'b0;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RP}) begin
            failures++;
            $display("FAIL rl_discard_addr actual req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RP);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step;
            if (imem_req && imem_addr !== RP) found = 1'b1;
        end
        checks++;
        if (!found || imem_addr !== 32'h0000_0100) begin
            failures++;
            $display("FAIL rl_new_addr actual found=%b addr=%h required addr=00000100", found, imem_addr);
        end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (id_valid) found = 1'b1;
            else step;
        end
        checks++;
        if ({found, id_pc, id_instr} !== {1'b1, 32'h0000_0100, mem_word(32'h0000_0100)}) begin
            failures++;
            $display("FAIL rl_first_id actual found=%b pc=%h instr=%h required pc=00000100 instr=%h", found, id_pc, id_instr, mem_word(32'h0000_0100));
        end
    endtask

    task automatic test_redirect_ack;
        do_reset;
        step;
        checks++;
        if ({imem_req, imem_ack} !== 2'b11) begin
            failures++;
            $display("FAIL ra_ack actual req/ack=%b required=11", {imem_req, imem_ack});
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0040;
        step;
        redirect_valid = 1'b0;
        checks++;
        if ({id_valid, imem_req} !== 2'b00) begin
            failures++;
            $display("FAIL ra_no_push actual valid/req=%b required=00", {id_valid, imem_req});
        end
        step;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0040}) begin
            failures++;
            $display("FAIL ra_target actual req=%b addr=%h required req=1 addr=00000040", imem_req, imem_addr);
        end
        step;
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 32'h0000_0040}) begin
            failures++;
            $display("FAIL ra_id actual valid=%b pc=%h required pc=00000040", id_valid, id_pc);
        end
    endtask

    task automatic test_align_wrap;
        do_reset;
        id_ready = 1'b1;
        step;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step;
        redirect_valid = 1'b0;
        step;
        checks++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL aw_top_addr actual=%h required=fffffffc", imem_addr);
        end
        step;
        checks++;
        if ({imem_addr, id_pc} !== {32'h0, 32'hFFFF_FFFC}) begin
            failures++;
            $display("FAIL aw_wrap actual addr=%h id_pc=%h required addr=00000000 id_pc=fffffffc", imem_addr, id_pc);
        end
        step;
        checks++;
        if ({id_valid, id_pc, instr_count} !== {1'b1, 32'h0, 32'd1}) begin
            failures++;
            $display("FAIL aw_wrapped_id actual valid=%b pc=%h count=%0d required pc=00000000 count=1", id_valid, id_pc, instr_count);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        step;
        redirect_valid = 1'b0;
        checks++;
        if ({id_valid, instr_count} !== {1'b0, 32'd2}) begin
            failures++;
            $display("FAIL aw_redirect_pop actual valid=%b count=%0d required valid=0 count=2", id_valid, instr_count);
        end
        step;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0100}) begin
            failures++;
            $display("FAIL aw_align actual req=%b addr=%h required req=1 addr=00000100", imem_req, imem_addr);
        end
        step;
        checks++;
        if ({id_valid, id_pc} !== {1'b1, 32'h0000_0100}) begin
            failures++;
            $display("FAIL aw_align_id actual valid=%b pc=%h required pc=00000100", id_valid, id_pc);
        end
    endtask

    task automatic test_reset_mid;
        do_reset;
        id_ready = 1'b1;
        step;
        step;
        step;
        step;
        id_ready = 1'b0;
        step;
        checks++;
        if ({imem_req, id_valid, instr_count} !== {1'b0, 1'b1, 32'd2}) begin
            failures++;
            $display("FAIL rm_full actual req=%b valid=%b count=%0d required req=0 valid=1 count=2", imem_req, id_valid, instr_count);
        end
        mem_lat = 3;
        id_ready = 1'b1;
        step;
        id_ready = 1'b0;
        checks++;
        if ({imem_req, imem_ack, id_valid} !== 3'b101) begin
            failures++;
            $display("FAIL rm_outstanding actual req/ack/valid=%b required=101", {imem_req, imem_ack, id_valid});
        end
        rst = 1'b1;
        step;
        checks++;
        if ({imem_req, id_valid, instr_count} !== {1'b0, 1'b0, 32'd0}) begin
            failures++;
            $display("FAIL rm_cleared actual req=%b valid=%b count=%0d required 0/0/0", imem_req, id_valid, instr_count);
        end
        rst = 1'b0;
        step;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RP}) begin
            failures++;
            $display("FAIL rm_restart actual req=%b addr=%h required req=1 addr=%h", imem_req, imem_addr, RP);
        end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_latency;
        test_redirect_ack;
        test_align_wrap;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 2, giving the number of fetch-buffer entries; only the value 2 is supported.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 imem_req  out  1  fetch request is valid.
REQ-007 imem_addr  out  32  fetch address, word aligned.
REQ-008 imem_ack  in  1  instruction memory returns data and completes the request.
REQ-009 imem_rdata  in  32  instruction word; valid when imem_ack=1.
REQ-010 redirect_valid  in  1  taken branch or jump from execute.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 id_valid  out  1  instruction available to the decode/control stage.
REQ-013 id_ready  in  1  decode accepts the instruction.
REQ-014 id_instr  out  32  instruction word.
REQ-015 id_pc  out  32  PC of id_instr.
REQ-016 id_opcode  out  7  id_instr[6:0], fed to the control unit.
REQ-017 id_funct3  out  3  id_instr[14:12].
REQ-018 id_funct7  out  7  id_instr[31:25].
REQ-019 instr_count  out  32  count of accepted instructions.

Function
REQ-020 SHALL implement the FSM states IDLE, REQ and DISCARD; imem_req SHALL be 1 exactly in REQ or DISCARD.
REQ-021 imem_addr SHALL hold stable while imem_req=1 and imem_ack=0; at most one request SHALL be outstanding.
REQ-022 Transition IDLE->REQ SHALL occur when (fifo_count - pop) < FIFO_DEPTH.
REQ-023 In REQ, on ack: push {fetch_pc, imem_rdata}, set fetch_pc += 4, stay in REQ if there is space after the push/pop, else go to IDLE.
REQ-024 fetch_pc arithmetic SHALL be modulo 2^32; 32'hFFFF_FFFC + 4 SHALL wrap to 0.
REQ-025 A redirect SHALL flush the FIFO, set fetch_pc = {redirect_pc[31:2],2'b00}, and move state REQ->DISCARD when no ack occurs in the same cycle, otherwise to IDLE.
REQ-026 In DISCARD, the FSM SHALL keep the old address requested, drop the data on ack and go to IDLE; no push occurs.
REQ-027 A redirect in DISCARD SHALL update fetch_pc and remain in DISCARD.
REQ-028 A redirect simultaneous with an ack SHALL drop the ack data.
REQ-029 A redirect simultaneous with an id handshake SHALL take priority; the handshake SHALL still count in instr_count.
REQ-030 The id_* outputs SHALL come from the FIFO head; id_valid SHALL be (fifo_count != 0).
REQ-031 The head SHALL be held stable while id_valid=1 and id_ready=0.
REQ-032 Push and pop in the same cycle SHALL be allowed, with count unchanged.
REQ-033 Push into a full FIFO SHALL never occur (guaranteed by REQ-022/023).
REQ-034 With a zero-wait memory (ack while req=1) and id_ready=1, throughput SHALL be one instruction per cycle.
REQ-035 Ack-to-id_valid latency SHALL be 1 cycle.
REQ-036 instr_count SHALL increment on id_valid & id_ready and wrap at 2^32.

Reset
REQ-037 On rst=1 at a clock edge: state=IDLE, fetch_pc=RESET_PC, FIFO empty, instr_count=0.
REQ-038 During reset, imem_req=0 and id_valid=0.
REQ-039 Reset mid-request SHALL abandon the request; instruction memory shares rst, so no stale ack follows.
REQ-040 The first imem_req SHALL assert in the cycle after rst deasserts, with imem_addr=RESET_PC.

Structure
REQ-041 Package riscv_pkg SHALL hold the opcode constants (OP_IMM 7'h13, LOAD 7'h03, OP 7'h33, JAL 7'h6F, STORE 7'h23, LUI 7'h37, BRANCH 7'h63), the fetch-state enum and the default RESET_PC.
REQ-042 The 2-entry buffer SHALL be the sub-module fetch_fifo (parameter WIDTH=64, sync reset, flush input).

Verification
REQ-043 Zero-wait memory with id_ready=1 after reset -> addresses 0,4,8,... on consecutive cycles; id_pc follows 1 cycle behind.
REQ-044 id_ready=0 for 5 cycles -> FIFO fills to 2, imem_req drops, and id_instr holds; on release, no instruction is lost or duplicated.
REQ-045 3-cycle ack latency, redirect_pc=32'h100 one cycle after the request issues -> the old ack data is dropped, the next imem_addr is 32'h100, and the next id_pc is 32'h100.
REQ-046 Redirect with imem_ack in the same cycle -> no push; imem_addr=target on the following request.
REQ-047 redirect_pc=32'hFFFF_FFFC -> the next fetch is at 32'h0; redirect_pc=32'h103 -> fetch at 32'h100.
REQ-048 rst asserted mid-request with FIFO holding 2 entries -> id_valid=0, instr_count=0, and the next imem_addr is RESET_PC.
